// File: rtl/iob_cpu_bus_adapter.sv
// Bridge from a split command/response CPU bus to the IOb native bus.
// Commands are queued in a small FIFO and issued one at a time; reads (and optionally writes) return a response.
module iob_cpu_bus_adapter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 2,
  parameter int TIMEOUT   = 0,
  parameter int WRITE_RSP = 0,
  parameter int REMAP_EN  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           boot,
  input  logic                           cpu_cmd_valid,
  output logic                           cpu_cmd_ready,
  input  logic                           cpu_cmd_wr,
  input  logic [ADDR_W-1:0]              cpu_cmd_addr,
  input  logic [DATA_W-1:0]              cpu_cmd_wdata,
  input  logic [1:0]                     cpu_cmd_size,
  output logic                           cpu_rsp_valid,
  output logic [DATA_W-1:0]              cpu_rsp_data,
  output logic                           cpu_rsp_error,
  output logic                           iob_valid,
  output logic [ADDR_W-1:0]              iob_addr,
  output logic [DATA_W-1:0]              iob_wdata,
  output logic [DATA_W/8-1:0]            iob_wstrb,
  input  logic                           iob_ready,
  input  logic [DATA_W-1:0]              iob_rdata,
  output logic [$clog2(CMD_DEPTH+1)-1:0] pending
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W  = $clog2(CMD_DEPTH + 1);
  localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CMD_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } cmd_t;

  cmd_t             mem [CMD_DEPTH];
  cmd_t             new_cmd;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;
  logic             full;
  logic             empty;
  logic             push;
  logic             done;
  logic             expired;
  logic             pop;
  logic             rsp_due;
  logic [3:0]       nbytes;
  logic [OFF_W-1:0] offset;
  logic [STRB_W-1:0] mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign cpu_cmd_ready = ~full & ~rst;
  assign push          = cpu_cmd_valid & cpu_cmd_ready;
  assign pending       = count;

  // Strobes cover the naturally aligned window of 2^size bytes containing the address.
  // NOTE: every variable is assigned at the top of the block so no path leaves one unassigned (no latch).
  always_comb begin
    nbytes = 4'd1 << cpu_cmd_size;
    if (32'(nbytes) > STRB_W) nbytes = 4'(STRB_W);
    offset = cpu_cmd_addr[OFF_W-1:0] & ~OFF_W'(nbytes - 4'd1);
    mask   = ({STRB_W{1'b1}} >> (STRB_W - int'(nbytes))) << offset;

    new_cmd.wr    = cpu_cmd_wr;
    new_cmd.addr  = cpu_cmd_addr;
    new_cmd.wdata = cpu_cmd_wdata;
    new_cmd.wstrb = cpu_cmd_wr ? mask : '0;
    if (REMAP_EN != 0)
      new_cmd.addr[ADDR_W-1] = (cpu_cmd_addr[ADDR_W-1] ^ ~boot) & ~cpu_cmd_addr[ADDR_W-2];
  end

  assign head    = mem[rd_ptr];
  assign done    = ~empty & iob_ready;
  assign expired = (TIMEOUT != 0) & ~empty & ~iob_ready & (timer == TMR_LAST);
  assign pop     = done | expired;
  assign rsp_due = pop & (~head.wr | (WRITE_RSP != 0));

  // Stale storage is masked while the FIFO is empty, so outputs read 0 after reset.
  assign iob_valid = ~empty;
  assign iob_addr  = empty ? '0 : head.addr;
  assign iob_wdata = empty ? '0 : head.wdata;
  assign iob_wstrb = empty ? '0 : head.wstrb;

  // NOTE: the entry storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      timer  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop)
        timer <= '0;
      else if (~empty & ~iob_ready)
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_error <= 1'b0;
      cpu_rsp_data  <= '0;
    end else begin
      cpu_rsp_valid <= rsp_due;
      cpu_rsp_error <= rsp_due & expired;
      cpu_rsp_data  <= (done & ~head.wr) ? iob_rdata : '0;
    end
  end

endmodule

// File: tb/tb_iob_cpu_bus_adapter.sv
// Directed bench for iob_cpu_bus_adapter (64-bit data, depth 2, timeout 4, remap on).
// A queue-based reference model is compared against the DUT on every falling edge.
module tb_iob_cpu_bus_adapter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              boot = 1'b1;
  logic              cpu_cmd_valid = 1'b0;
  logic              cpu_cmd_ready;
  logic              cpu_cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cpu_cmd_addr = '0;
  logic [DATA_W-1:0] cpu_cmd_wdata = '0;
  logic [1:0]        cpu_cmd_size = '0;
  logic              cpu_rsp_valid;
  logic [DATA_W-1:0] cpu_rsp_data;
  logic              cpu_rsp_error;
  logic              iob_valid;
  logic [ADDR_W-1:0] iob_addr;
  logic [DATA_W-1:0] iob_wdata;
  logic [7:0]        iob_wstrb;
  logic              iob_ready = 1'b0;
  logic [DATA_W-1:0] iob_rdata;
  logic [1:0]        pending;

  logic              use_fix = 1'b0;
  logic [DATA_W-1:0] rdata_fix = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Slave read data identifies the request it answers unless a fixed value is forced.
  assign iob_rdata = use_fix ? rdata_fix : {32'hC0DE0000, iob_addr};

  iob_cpu_bus_adapter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT), .WRITE_RSP(0), .REMAP_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .boot(boot),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_cmd_wr(cpu_cmd_wr), .cpu_cmd_addr(cpu_cmd_addr),
    .cpu_cmd_wdata(cpu_cmd_wdata), .cpu_cmd_size(cpu_cmd_size),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .cpu_rsp_error(cpu_rsp_error),
    .iob_valid(iob_valid), .iob_addr(iob_addr), .iob_wdata(iob_wdata),
    .iob_wstrb(iob_wstrb), .iob_ready(iob_ready), .iob_rdata(iob_rdata),
    .pending(pending)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } ent_t;

  ent_t        q[$];
  int          age = 0;
  bit          after_reset = 1'b1;
  logic        exp_rsp_v = 1'b0;
  logic        exp_rsp_e = 1'b0;
  logic [63:0] exp_rsp_d = '0;
  logic        m_acc;
  ent_t        m_ent;

  function automatic logic [7:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    int n;
    int start;
    logic [7:0] m;
    n = 1 << size;
    start = ((int'(addr) % 8) / n) * n;
    m = '0;
    for (int b = 0; b < 8; b++)
      if (b >= start && b < start + n) m[b] = 1'b1;
    return m;
  endfunction

  // Bit 30 set pins the region to bit31=0; otherwise bit 31 flips outside boot.
  function automatic logic [31:0] model_remap(input logic [31:0] a, input logic b);
    logic [31:0] r;
    r = a;
    if (a[30]) r[31] = 1'b0;
    else if (!b) r[31] = ~a[31];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      age = 0;
      exp_rsp_v = 1'b0;
      exp_rsp_e = 1'b0;
      exp_rsp_d = '0;
      after_reset = 1'b1;
    end else begin
      m_acc = cpu_cmd_valid && (q.size() < DEPTH);
      exp_rsp_v = 1'b0;
      exp_rsp_e = 1'b0;
      exp_rsp_d = '0;
      if (q.size() != 0) begin
        if (iob_ready || (age + 1 == TIMEOUT)) begin
          if (!q[0].wr) begin
            exp_rsp_v = 1'b1;
            exp_rsp_e = !iob_ready;
            exp_rsp_d = iob_ready ? iob_rdata : 64'h0;
          end
          void'(q.pop_front());
          age = 0;
        end else begin
          age++;
        end
      end
      if (m_acc) begin
        m_ent.wr    = cpu_cmd_wr;
        m_ent.addr  = model_remap(cpu_cmd_addr, boot);
        m_ent.wdata = cpu_cmd_wdata;
        m_ent.wstrb = cpu_cmd_wr ? model_strb(cpu_cmd_size, cpu_cmd_addr) : 8'h00;
        q.push_back(m_ent);
        after_reset = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmd_ready", 64'(cpu_cmd_ready), 64'(!rst && q.size() < DEPTH));
    check("pending", 64'(pending), 64'(q.size()));
    check("iob_valid", 64'(iob_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("iob_addr", 64'(iob_addr), 64'(q[0].addr));
      check("iob_wdata", iob_wdata, q[0].wdata);
      check("iob_wstrb", 64'(iob_wstrb), 64'(q[0].wstrb));
    end else if (after_reset) begin
      check("iob_addr_idle", 64'(iob_addr), 64'h0);
      check("iob_wstrb_idle", 64'(iob_wstrb), 64'h0);
      check("rsp_data_idle", cpu_rsp_data, 64'h0);
    end
    check("rsp_valid", 64'(cpu_rsp_valid), 64'(exp_rsp_v));
    if (exp_rsp_v) begin
      check("rsp_error", 64'(cpu_rsp_error), 64'(exp_rsp_e));
      check("rsp_data", cpu_rsp_data, exp_rsp_d);
    end
  end

  logic [63:0] rsp_data_log[$];
  int          rsp_cyc_log[$];
  always @(negedge clk) begin
    if (cpu_rsp_valid) begin
      rsp_data_log.push_back(cpu_rsp_data);
      rsp_cyc_log.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [1:0] size);
    logic seen;
    cpu_cmd_valid = 1'b1;
    cpu_cmd_wr    = wr;
    cpu_cmd_addr  = addr;
    cpu_cmd_wdata = wdata;
    cpu_cmd_size  = size;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_cmd_ready;
      @(posedge clk);
    end
    #1;
    cpu_cmd_valid = 1'b0;
    if (!seen) check("send_accept_timeout", 64'(seen), 64'h1);
  endtask

  // Called in the low phase; holds iob_ready for exactly one rising edge.
  task automatic ack_one();
    iob_ready = 1'b1;
    align();
    iob_ready = 1'b0;
  endtask

  task automatic write_strb(input logic [31:0] addr, input logic [1:0] size, input logic [7:0] exp);
    send(1'b1, addr, 64'h0123_4567_89AB_CDEF, size);
    @(negedge clk);
    check("wr_strb", 64'(iob_wstrb), 64'(exp));
    ack_one();
  endtask

  int base;
  int cnt;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cpu_cmd_ready), 64'h0);
    check("rst_iob_valid", 64'(iob_valid), 64'h0);
    check("rst_rsp_valid", 64'(cpu_rsp_valid), 64'h0);
    align();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cpu_cmd_ready), 64'h1);
    align();

    // Byte write: lane 3 of the low word
    send(1'b1, 32'h1003, 64'h0000_0000_AA00_0000, 2'd0);
    @(negedge clk);
    check("bw_valid", 64'(iob_valid), 64'h1);
    check("bw_addr", 64'(iob_addr), 64'h1003);
    check("bw_strb", 64'(iob_wstrb), 64'h08);
    check("bw_wdata", iob_wdata, 64'h0000_0000_AA00_0000);
    ack_one();
    @(negedge clk);
    check("bw_no_rsp", 64'(cpu_rsp_valid), 64'h0);
    align();

    // Half read at 0x6 and dword read, both answered in the first valid cycle
    use_fix = 1'b1;
    rdata_fix = 64'h1122_3344_5566_7788;
    send(1'b0, 32'h6, 64'h0, 2'd1);
    @(negedge clk);
    check("hr_strb", 64'(iob_wstrb), 64'h0);
    ack_one();
    @(negedge clk);
    check("hr_rsp_valid", 64'(cpu_rsp_valid), 64'h1);
    check("hr_rsp_data", cpu_rsp_data, 64'h1122_3344_5566_7788);
    align();
    rdata_fix = 64'h0123_4567_89AB_CDEF;
    send(1'b0, 32'h8, 64'h0, 2'd3);
    @(negedge clk);
    ack_one();
    @(negedge clk);
    check("dr_rsp_data", cpu_rsp_data, 64'h0123_4567_89AB_CDEF);
    align();
    use_fix = 1'b0;

    // Strobe shapes, including a misaligned word
    write_strb(32'h10, 2'd3, 8'hFF);
    write_strb(32'h6,  2'd1, 8'hC0);
    write_strb(32'h5,  2'd2, 8'hF0);
    write_strb(32'h7,  2'd1, 8'hC0);

    // Back-to-back: three reads, depth 2, slave stalled then released
    base = rsp_data_log.size();
    send(1'b0, 32'h100, 64'h0, 2'd2);
    send(1'b0, 32'h104, 64'h0, 2'd2);
    @(negedge clk);
    check("b2b_pending", 64'(pending), 64'h2);
    check("b2b_full_ready", 64'(cpu_cmd_ready), 64'h0);
    iob_ready = 1'b1;
    send(1'b0, 32'h108, 64'h0, 2'd2);
    repeat (2) align();
    iob_ready = 1'b0;
    align();
    check("b2b_rsp_count", 64'(rsp_data_log.size() - base), 64'h3);
    if (rsp_data_log.size() >= base + 3) begin
      check("b2b_rsp0", rsp_data_log[base],     64'hC0DE_0000_0000_0100);
      check("b2b_rsp1", rsp_data_log[base + 1], 64'hC0DE_0000_0000_0104);
      check("b2b_rsp2", rsp_data_log[base + 2], 64'hC0DE_0000_0000_0108);
      check("b2b_gap1", 64'(rsp_cyc_log[base + 1] - rsp_cyc_log[base]), 64'h1);
      check("b2b_gap2", 64'(rsp_cyc_log[base + 2] - rsp_cyc_log[base + 1]), 64'h1);
    end

    // Timeout: slave never answers
    send(1'b0, 32'h200, 64'h0, 2'd2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (iob_valid) cnt++;
      else break;
    end
    check("to_valid_cycles", 64'(cnt), 64'h4);
    check("to_rsp_valid", 64'(cpu_rsp_valid), 64'h1);
    check("to_rsp_error", 64'(cpu_rsp_error), 64'h1);
    check("to_rsp_data", cpu_rsp_data, 64'h0);
    align();
    send(1'b0, 32'h204, 64'h0, 2'd2);
    @(negedge clk);
    ack_one();
    @(negedge clk);
    check("to_next_valid", 64'(cpu_rsp_valid), 64'h1);
    check("to_next_error", 64'(cpu_rsp_error), 64'h0);
    check("to_next_data", cpu_rsp_data, 64'hC0DE_0000_0000_0204);
    align();

    // Remap, boot sampled at accept
    boot = 1'b0;
    send(1'b0, 32'h4000_0010, 64'h0, 2'd2);
    @(negedge clk);
    check("remap_b0_4000", 64'(iob_addr), 64'h4000_0010);
    ack_one();
    send(1'b0, 32'h0000_1000, 64'h0, 2'd2);
    boot = 1'b1;
    @(negedge clk);
    check("remap_b0_1000", 64'(iob_addr), 64'h8000_1000);
    ack_one();
    send(1'b0, 32'h0000_1000, 64'h0, 2'd2);
    @(negedge clk);
    check("remap_b1_1000", 64'(iob_addr), 64'h0000_1000);
    ack_one();
    boot = 1'b0;
    send(1'b0, 32'h8000_1000, 64'h0, 2'd2);
    @(negedge clk);
    check("remap_b0_8000", 64'(iob_addr), 64'h0000_1000);
    ack_one();
    boot = 1'b1;
    align();

    // Reset with two pending entries
    send(1'b0, 32'h300, 64'h0, 2'd2);
    send(1'b0, 32'h304, 64'h0, 2'd2);
    rst = 1'b1;
    #1;
    check("mrst_iob_valid", 64'(iob_valid), 64'h0);
    check("mrst_pending", 64'(pending), 64'h0);
    check("mrst_cmd_ready", 64'(cpu_cmd_ready), 64'h0);
    base = rsp_data_log.size();
    align();
    rst = 1'b0;
    repeat (4) align();
    check("mrst_no_rsp", 64'(rsp_data_log.size() - base), 64'h0);
    send(1'b0, 32'h400, 64'h0, 2'd2);
    @(negedge clk);
    ack_one();
    @(negedge clk);
    check("mrst_new_valid", 64'(cpu_rsp_valid), 64'h1);
    check("mrst_new_data", cpu_rsp_data, 64'hC0DE_0000_0000_0400);
    repeat (2) align();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iob_cpu_bus_adapter.md
# iob_cpu_bus_adapter

Parametrised bridge between a split command/response CPU bus (VexRiscv-style iBus/dBus) and the IOb native bus (valid/addr/wdata/wstrb, ready/rdata). It is the successor of the single-register CPU wrapper logic and adds:

- a command FIFO of configurable depth;
- generic byte-strobe generation for any DATA_W;
- optional write responses;
- a bus timeout that returns an error response;
- optional boot-dependent external-memory address remapping.

One instance sits on each CPU bus, between the core and the system interconnect.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; power of 2, minimum 32.
- CMD_DEPTH, 2, command FIFO depth; power of 2, minimum 1.
- TIMEOUT, 0, cycles iob_valid may stay high without iob_ready before an error response; 0 disables the timeout.
- WRITE_RSP, 0, 1 = writes also produce a CPU response.
- REMAP_EN, 0, 1 = boot-dependent MSB address remap.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- boot  in  1  1 while the boot ROM is running.
- cpu_cmd_valid  in  1  command valid.
- cpu_cmd_ready  out  1  command accepted when valid & ready.
- cpu_cmd_wr  in  1  1 = write.
- cpu_cmd_addr  in  ADDR_W  byte address.
- cpu_cmd_wdata  in  DATA_W  write data, lane-aligned.
- cpu_cmd_size  in  2  log2 of access bytes.
- cpu_rsp_valid  out  1  one-cycle response pulse.
- cpu_rsp_data  out  DATA_W  read data.
- cpu_rsp_error  out  1  response is a timeout error.
- iob_valid  out  1  native request valid.
- iob_addr  out  ADDR_W  native address.
- iob_wdata  out  DATA_W  native write data.
- iob_wstrb  out  DATA_W/8  byte strobes; 0 = read.
- iob_ready  in  1  native completion.
- iob_rdata  in  DATA_W  read data, valid with iob_ready.
- pending  out  $clog2(CMD_DEPTH+1)  current FIFO occupancy.

## Operation
- **Accept:**
  - cpu_cmd_ready = ~full & ~rst.
  - On valid & ready, push {wr, translated addr, wdata, wstrb} into the FIFO.
  - The push is decided on the current count only; a pop in the same cycle does not free a slot for that cycle.
- **Strobe generation:**
  - nbytes = 2^size, clamped to DATA_W/8 when 2^size > DATA_W/8.
  - mask = (2^nbytes − 1) << (addr[log2(DATA_W/8)−1:0] & ~(nbytes−1)); misaligned low bits are masked off.
  - wstrb = wr ? mask : 0.
- **Remap:** applied when REMAP_EN=1, using boot sampled at accept.
  - iob_addr[ADDR_W−1] = (addr[ADDR_W−1] ^ ~boot) & ~addr[ADDR_W−2].
  - All other address bits pass through unchanged.
- **Issue:**
  - iob_valid = FIFO non-empty.
  - iob_addr, iob_wdata and iob_wstrb come from the head entry, registered, and stay stable until the entry is popped.
  - Only one native request is in flight at a time.
- **Complete:** when iob_valid & iob_ready, pop the head.
  - Read, or write with WRITE_RSP=1: next cycle cpu_rsp_valid=1, cpu_rsp_error=0, cpu_rsp_data = iob_rdata (0 for writes).
  - Write with WRITE_RSP=0: no response.
- **Timeout:**
  - Counter clears when a new head is presented and increments each cycle with iob_valid & ~iob_ready.
  - If the counter reaches TIMEOUT while iob_ready=0, the head is popped at that edge. Next cycle: cpu_rsp_valid=1, cpu_rsp_error=1, cpu_rsp_data=0. The write/WRITE_RSP rule applies.
  - A late iob_ready for a dropped request is not distinguishable; the interconnect guarantees none arrives.
- **Reset:** rst clears the FIFO, counters and all registered outputs immediately; requests in flight are discarded silently.

## Timing
- **Reset values:** cpu_cmd_ready=0 while rst=1 and 1 after release; every other output is 0.
- **Accept to issue:** accept at edge t into an empty FIFO → iob_valid=1 in cycle t+1.
- **Issue to response:** iob_ready in cycle u → cpu_rsp_valid in cycle u+1 for exactly 1 cycle.
  - Minimum read latency is 2 cycles from accept to response when iob_ready is returned in the first valid cycle.
- **Back-to-back:** with multiple entries, the next head is presented in cycle u+1 with no bubble; iob_valid stays 1.
- **Full:** cpu_cmd_ready=0 while pending=CMD_DEPTH and returns to 1 in the cycle after a pop.
- **Timeout with TIMEOUT=N:** iob_valid is high for exactly N cycles, then the error response follows in the next cycle.
- The CPU must always accept responses; there is no response backpressure.

## Test plan
- **Byte write:** size=0, addr=0x1003, wdata=0xAA000000 → iob_wstrb=4'b1000, iob_addr=0x1003, no cpu_rsp (WRITE_RSP=0).
- **Half and word reads, DATA_W=64:** size=1 at addr 0x6 → iob_wstrb=0; read returns 0x1122334455667788 → cpu_rsp_data=0x1122334455667788 one cycle after iob_ready. Size=3 → full word.
- **Back-to-back:** 3 reads with CMD_DEPTH=2 and iob_ready held 0 → pending reaches 2, cpu_cmd_ready=0. Release iob_ready → 3 responses on consecutive cycles, in order.
- **Timeout:** TIMEOUT=4, read, iob_ready held 0 → iob_valid high 4 cycles, then cpu_rsp_valid=1, cpu_rsp_error=1, data 0; a following command issues normally.
- **Remap:** REMAP_EN=1.
  - boot=0, addr 0x00001000 → iob_addr 0x80001000.
  - boot=1 → 0x00001000.
  - addr 0x40000010 with boot=0 → 0x40000010.
- **Reset mid-operation:** assert rst with 2 pending entries → iob_valid=0 and pending=0 immediately; no response after release; a new command completes normally.
